// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and helpers for the memory-access stage
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-SRAM request/response bus
interface mem_access_if;
  import mem_access_pkg::*;

  logic              data_req;
  logic              data_wr;
  logic [DATA_W-1:0] data_addr;
  logic [STRB_W-1:0] data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication/strobes and load lane extraction/extension
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  always_comb begin
    w_byte      = i_rdata[{i_addr_lo, 3'b000} +: BYTE_W];
    w_half      = i_rdata[{i_addr_lo[1], 4'b0000} +: HALF_W];
    o_wstrb     = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_size)
      SIZE_BYTE: begin
        o_wstrb     = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[BYTE_W-1:0]}};
        o_load_data = i_unsigned ? {{(DATA_W-BYTE_W){1'b0}}, w_byte}
                                 : {{(DATA_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      end
      SIZE_HALF: begin
        o_wstrb     = 4'b0011 << i_addr_lo;
        o_wdata     = {2{i_store_data[HALF_W-1:0]}};
        o_load_data = i_unsigned ? {{(DATA_W-HALF_W){1'b0}}, w_half}
                                 : {{(DATA_W-HALF_W){w_half[HALF_W-1]}}, w_half};
      end
      default: begin
        o_wstrb     = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: stage register, data-SRAM handshake FSM, load/store alignment
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_inst,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_write_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  mem_access_if.master      mem,
  output logic [4:0]        write_addr_out,
  output logic [31:0]       write_data_alu,
  output logic [31:0]       write_data_mem,
  output logic              reg_write_final,
  output logic              mem_to_reg_final,
  output logic [31:0]       inst_out,
  output logic              mem_stall,
  output logic              addr_err
);

  state_e      r_state;
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_alu;
  logic [31:0] r_sdata;
  logic [4:0]  r_waddr;
  logic        r_regw;
  logic        r_m2r;
  logic        r_mrd;
  logic        r_mwr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_rdata;
  logic        r_addr_err;

  logic              w_memop;
  logic              w_misal;
  logic              w_advance;
  logic              w_capture_req;
  logic              w_data_ok_keep;
  logic [STRB_W-1:0] w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load;

  assign w_memop   = r_valid & (r_mrd | r_mwr);
  assign w_misal   = is_misaligned(r_size, r_alu[1:0]);
  assign mem_stall = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_advance = !stall_in && !mem_stall;
  assign w_capture_req = ex_valid && (ex_mem_read || ex_mem_write) && !flush
                         && !is_misaligned(ex_mem_size, ex_alu_result[1:0]);
  // A flushed (invalid) stage still drains its in-flight response but never keeps the data
  assign w_data_ok_keep = mem.data_data_ok && r_valid && !flush &&
                          (((r_state == ST_REQ) && mem.data_addr_ok) || (r_state == ST_WAIT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_inst     <= '0;
      r_alu      <= '0;
      r_sdata    <= '0;
      r_waddr    <= '0;
      r_regw     <= 1'b0;
      r_m2r      <= 1'b0;
      r_mrd      <= 1'b0;
      r_mwr      <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      if (w_advance) begin
        r_valid    <= ex_valid && !flush;
        r_inst     <= ex_inst;
        r_alu      <= ex_alu_result;
        r_sdata    <= ex_store_data;
        r_waddr    <= ex_write_addr;
        r_regw     <= ex_reg_write;
        r_m2r      <= ex_mem_to_reg;
        r_mrd      <= ex_mem_read;
        r_mwr      <= ex_mem_write;
        r_size     <= ex_mem_size;
        r_uns      <= ex_mem_unsigned;
        r_addr_err <= ex_valid && (ex_mem_read || ex_mem_write) && !flush
                      && is_misaligned(ex_mem_size, ex_alu_result[1:0]);
      end else if (flush) begin
        r_valid <= 1'b0;
      end

      if (w_data_ok_keep) r_rdata <= mem.data_rdata;

      case (r_state)
        ST_IDLE: if (w_advance) r_state <= w_capture_req ? ST_REQ : ST_IDLE;
        ST_REQ: begin
          if (flush)                  r_state <= ST_IDLE;
          else if (mem.data_addr_ok)  r_state <= mem.data_data_ok ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.data_data_ok) r_state <= (r_valid && !flush) ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          if (flush)          r_state <= ST_IDLE;
          else if (w_advance) r_state <= w_capture_req ? ST_REQ : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mem_align u_align (
    .i_size       (r_size),
    .i_addr_lo    (r_alu[1:0]),
    .i_unsigned   (r_uns),
    .i_store_data (r_sdata),
    .i_rdata      (r_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load)
  );

  assign mem.data_req   = (r_state == ST_REQ);
  assign mem.data_wr    = r_valid & r_mwr;
  assign mem.data_addr  = {r_alu[31:2], 2'b00};
  assign mem.data_wstrb = (r_valid & r_mwr) ? w_wstrb : '0;
  assign mem.data_wdata = w_wdata;

  assign write_addr_out   = r_waddr;
  assign write_data_alu   = r_alu;
  assign write_data_mem   = w_load;
  assign reg_write_final  = r_valid & r_regw & ~(w_memop & w_misal);
  assign mem_to_reg_final = r_m2r;
  assign inst_out         = r_inst;
  assign addr_err         = r_addr_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_in, flush;
  logic        ex_valid;
  logic [31:0] ex_inst, ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_addr;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [4:0]  write_addr_out;
  logic [31:0] write_data_alu, write_data_mem, inst_out;
  logic        reg_write_final, mem_to_reg_final, mem_stall, addr_err;

  mem_access_if mif();

  mem_access dut (
    .clk(clk), .rstn(rstn), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_addr(ex_write_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .mem(mif),
    .write_addr_out(write_addr_out), .write_data_alu(write_data_alu),
    .write_data_mem(write_data_mem), .reg_write_final(reg_write_final),
    .mem_to_reg_final(mem_to_reg_final), .inst_out(inst_out),
    .mem_stall(mem_stall), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic st, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] inst);
    ex_valid = 1'b1;        ex_inst = inst;          ex_alu_result = addr;
    ex_store_data = sdata;  ex_write_addr = 5'd9;    ex_reg_write = !st;
    ex_mem_to_reg = !st;    ex_mem_read = !st;       ex_mem_write = st;
    ex_mem_size = size;     ex_mem_unsigned = uns;
  endtask

  task automatic bubble();
    ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rd);
    mif.data_addr_ok = aok; mif.data_data_ok = dok; mif.data_rdata = rd;
  endtask

  // Capture, one REQ cycle answered with addr_ok+data_ok together, then DONE and back to IDLE
  task automatic run_vec(input vec_t v, input string tag);
    present(v.st, v.size, v.uns, v.addr, v.sdata, 32'hC0DE_0000 | v.addr);
    tick();
    bubble();
    check({tag, "_req"}, {31'b0, mif.data_req}, 32'd1);
    check({tag, "_stall_req"}, {31'b0, mem_stall}, 32'd1);
    check({tag, "_addr"}, mif.data_addr, {v.addr[31:2], 2'b00});
    check({tag, "_wr"}, {31'b0, mif.data_wr}, {31'b0, v.st});
    if (v.st) begin
      check({tag, "_wstrb"}, {28'b0, mif.data_wstrb}, {28'b0, v.e_strb});
      check({tag, "_wdata"}, mif.data_wdata, v.e_wdata);
    end
    set_mem(1'b1, 1'b1, v.rdata);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    check({tag, "_stall_done"}, {31'b0, mem_stall}, 32'd0);
    check({tag, "_regw"}, {31'b0, reg_write_final}, {31'b0, !v.st});
    if (!v.st) check({tag, "_load"}, write_data_mem, v.e_load);
    tick();
  endtask

  initial begin
    //           st    size   uns   addr          sdata         rdata         strb     wdata         load
    vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[3] = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'h8011_2233, 4'b0000, 32'h0,        32'hFFFF_8011};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        32'h1234_F00D, 4'b0000, 32'h0,        32'h0000_F00D};
    vecs[5] = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h1234_F00D, 4'b0000, 32'h0,        32'hFFFF_FFF0};
    vecs[6] = '{1'b1, 2'b00, 1'b0, 32'h0000_0105, 32'h0000_00A5, 32'h0,       4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[8] = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       4'b1111, 32'hCAFE_F00D, 32'h0};

    rstn = 1'b0; stall_in = 1'b0; flush = 1'b0;
    ex_inst = '0; ex_alu_result = '0; ex_store_data = '0; ex_write_addr = '0;
    ex_mem_to_reg = 1'b0; ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0;
    bubble();
    set_mem(1'b0, 1'b0, 32'h0);
    tick(); tick();

    check("rst_req",   {31'b0, mif.data_req}, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    check("rst_aerr",  {31'b0, addr_err}, 32'd0);
    check("rst_regw",  {31'b0, reg_write_final}, 32'd0);
    check("rst_wdm",   write_data_mem, 32'd0);
    check("rst_inst",  inst_out, 32'd0);
    check("rst_wstrb", {28'b0, mif.data_wstrb}, 32'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Half store with addr_ok held off for three REQ cycles
    present(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0030);
    tick();
    bubble();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hs_req%0d", k), {31'b0, mif.data_req}, 32'd1);
      check($sformatf("hs_addr%0d", k), mif.data_addr, 32'h0000_0200);
      check($sformatf("hs_strb%0d", k), {28'b0, mif.data_wstrb}, 32'hC);
      check($sformatf("hs_wdat%0d", k), mif.data_wdata, 32'hABCD_ABCD);
      check($sformatf("hs_wr%0d", k), {31'b0, mif.data_wr}, 32'd1);
      tick();
    end
    set_mem(1'b1, 1'b0, 32'h0);
    tick();
    set_mem(1'b0, 1'b1, 32'h0);
    check("hs_wait_req",   {31'b0, mif.data_req}, 32'd0);
    check("hs_wait_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    check("hs_done_stall", {31'b0, mem_stall}, 32'd0);
    tick();

    // Misaligned word load, held one extra cycle by stall_in
    present(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_0040);
    tick();
    bubble();
    stall_in = 1'b1;
    check("mis_aerr",  {31'b0, addr_err}, 32'd1);
    check("mis_req",   {31'b0, mif.data_req}, 32'd0);
    check("mis_regw",  {31'b0, reg_write_final}, 32'd0);
    check("mis_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    check("mis_aerr_pulse", {31'b0, addr_err}, 32'd0);
    check("mis_inst_held",  inst_out, 32'h0000_0040);
    stall_in = 1'b0;
    tick();

    // Flush while in REQ abandons the request immediately
    present(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0000_0050);
    tick();
    bubble();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fr_req",   {31'b0, mif.data_req}, 32'd0);
    check("fr_stall", {31'b0, mem_stall}, 32'd0);
    check("fr_regw",  {31'b0, reg_write_final}, 32'd0);

    // Flush while in WAIT: stall until data_ok, discard data
    run_vec(vecs[0], "pre_fw");
    present(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0060);
    tick();
    bubble();
    set_mem(1'b1, 1'b0, 32'h0);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fw_stall0", {31'b0, mem_stall}, 32'd1);
    check("fw_regw0",  {31'b0, reg_write_final}, 32'd0);
    check("fw_req0",   {31'b0, mif.data_req}, 32'd0);
    tick();
    check("fw_stall1", {31'b0, mem_stall}, 32'd1);
    set_mem(1'b0, 1'b1, 32'h1234_5678);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    check("fw_stall_end", {31'b0, mem_stall}, 32'd0);
    check("fw_req_end",   {31'b0, mif.data_req}, 32'd0);
    check("fw_regw_end",  {31'b0, reg_write_final}, 32'd0);
    check("fw_discard",   write_data_mem, 32'hDEAD_BEEF);
    tick();

    // stall_in while DONE holds the result and blocks the next instruction
    present(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_00F0);
    tick();
    set_mem(1'b1, 1'b1, 32'hA5A5_A5A5);
    stall_in = 1'b1;
    present(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_00F1);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    tick(); tick();
    check("sd_stall", {31'b0, mem_stall}, 32'd0);
    check("sd_inst",  inst_out, 32'h0000_00F0);
    check("sd_load",  write_data_mem, 32'hA5A5_A5A5);
    check("sd_regw",  {31'b0, reg_write_final}, 32'd1);
    check("sd_req",   {31'b0, mif.data_req}, 32'd0);
    stall_in = 1'b0;
    tick();
    bubble();
    check("sd_next_inst", inst_out, 32'h0000_00F1);
    check("sd_next_req",  {31'b0, mif.data_req}, 32'd1);
    check("sd_next_addr", mif.data_addr, 32'h0000_0400);
    set_mem(1'b1, 1'b1, 32'h0);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    tick();

    // Reset during WAIT, then a stray data_ok
    present(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0077);
    tick();
    bubble();
    set_mem(1'b1, 1'b0, 32'h0);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("rw_stall", {31'b0, mem_stall}, 32'd0);
    check("rw_req",   {31'b0, mif.data_req}, 32'd0);
    check("rw_inst",  inst_out, 32'd0);
    check("rw_alu",   write_data_alu, 32'd0);
    check("rw_wdm",   write_data_mem, 32'd0);
    check("rw_regw",  {31'b0, reg_write_final}, 32'd0);
    tick();
    rstn = 1'b1;
    set_mem(1'b0, 1'b1, 32'h5555_5555);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);
    check("rw_ok_stall", {31'b0, mem_stall}, 32'd0);
    check("rw_ok_req",   {31'b0, mif.data_req}, 32'd0);
    check("rw_ok_wdm",   write_data_mem, 32'd0);
    check("rw_ok_regw",  {31'b0, reg_write_final}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
